ip_arp_cache: RTL and testbench

IP_ARP_CACHE -- requirements
Module: ip_arp_cache

---
 rtl/ip_arp_cache.sv | 162 ++++++++++++++++
 tb/tb_ip_arp_cache.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_arp_cache.sv
// Direct-mapped IP->MAC cache: two-stage query pipeline, single-cycle learn writes, swept clear.
// Define ARP_CACHE_BROADCAST_BYPASS_EN to answer 255.255.255.255 with the broadcast MAC.
module ip_arp_cache #(
    parameter int CACHE_ADDR_WIDTH = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        query_request_valid,
    input  logic [31:0] query_request_ip,
    output logic        query_request_ready,
    output logic        query_response_valid,
    output logic        query_response_error,
    output logic [47:0] query_response_mac,
    input  logic        query_response_ready,
    input  logic        write_request_valid,
    input  logic [31:0] write_request_ip,
    input  logic [47:0] write_request_mac,
    output logic        write_request_ready,
    input  logic        clear_cache
);

    localparam int DEPTH = 1 << CACHE_ADDR_WIDTH;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    function automatic logic [CACHE_ADDR_WIDTH-1:0] f_index(input logic [31:0] ip);
        return CACHE_ADDR_WIDTH'(ip[31:16] ^ ip[15:0]);
    endfunction

    logic [DEPTH-1:0] r_valid;
    logic [31:0]      r_tag [DEPTH];
    logic [47:0]      r_mac [DEPTH];

    logic [0:0]                  r_state;
    logic [CACHE_ADDR_WIDTH-1:0] r_clr_idx;

    logic                        w_idle;
    logic                        w_resp_free;
    logic                        w_q_acc;
    logic                        w_wr_acc;
    logic                        w_wr_store;
    logic [CACHE_ADDR_WIDTH-1:0] w_q_idx;
    logic [CACHE_ADDR_WIDTH-1:0] w_wr_idx;

    logic        r_s1_valid;
    logic [31:0] r_s1_ip;
    logic        r_s1_ent_valid;
    logic [31:0] r_s1_tag;
    logic [47:0] r_s1_mac;
    logic        w_hit;
    logic        w_bcast;

    logic        r_resp_valid;
    logic        r_resp_err;
    logic [47:0] r_resp_mac;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_resp_free = !r_resp_valid || query_response_ready;

    assign query_request_ready = !rst && w_idle && w_resp_free;
    assign write_request_ready = !rst && w_idle;

    assign w_q_acc    = query_request_valid && query_request_ready;
    assign w_wr_acc   = write_request_valid && write_request_ready;
    assign w_wr_store = w_wr_acc && (write_request_ip != 32'd0) && (write_request_mac != 48'd0);
    assign w_q_idx    = f_index(query_request_ip);
    assign w_wr_idx   = f_index(write_request_ip);

    // Reset parks the FSM in CLEAR at index 0, so the sweep starts the cycle rst falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_cache) begin
                        r_state   <= ST_CLEAR;
                        r_clr_idx <= '0;
                    end
                end
                ST_CLEAR: begin
                    r_clr_idx <= r_clr_idx + CACHE_ADDR_WIDTH'(1);
                    if (r_clr_idx == '1) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Valid bits are initialised by the post-reset sweep rather than a reset branch.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_valid[r_clr_idx] <= 1'b0;
        end else if (w_wr_store) begin
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_store) begin
            r_tag[w_wr_idx] <= write_request_ip;
            r_mac[w_wr_idx] <= write_request_mac;
        end
    end

    // Read stage samples the table at the accept edge, i.e. before a same-cycle write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_resp_free) begin
            r_s1_valid <= w_q_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (w_q_acc) begin
            r_s1_ip        <= query_request_ip;
            r_s1_ent_valid <= r_valid[w_q_idx];
            r_s1_tag       <= r_tag[w_q_idx];
            r_s1_mac       <= r_mac[w_q_idx];
        end
    end

    assign w_hit = r_s1_ent_valid && (r_s1_tag == r_s1_ip);

`ifdef ARP_CACHE_BROADCAST_BYPASS_EN
    assign w_bcast = (r_s1_ip == 32'hFFFF_FFFF);
`else
    assign w_bcast = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_mac   <= 48'd0;
        end else if (w_resp_free) begin
            r_resp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                if (w_bcast) begin
                    r_resp_err <= 1'b0;
                    r_resp_mac <= 48'hFFFF_FFFF_FFFF;
                end else if (w_hit) begin
                    r_resp_err <= 1'b0;
                    r_resp_mac <= r_s1_mac;
                end else begin
                    r_resp_err <= 1'b1;
                    r_resp_mac <= 48'd0;
                end
            end
        end
    end

    assign query_response_valid = r_resp_valid && !rst;
    assign query_response_error = r_resp_err && !rst;
    assign query_response_mac   = rst ? 48'd0 : r_resp_mac;

endmodule

// File: tb/tb_ip_arp_cache.sv
// Self-checking bench for ip_arp_cache: directed scenarios plus a random write/query mix
// checked against an array-based model of the cache contents.
module tb_ip_arp_cache;

    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        query_request_valid;
    logic [31:0] query_request_ip;
    logic        query_request_ready;
    logic        query_response_valid;
    logic        query_response_error;
    logic [47:0] query_response_mac;
    logic        query_response_ready;
    logic        write_request_valid;
    logic [31:0] write_request_ip;
    logic [47:0] write_request_mac;
    logic        write_request_ready;
    logic        clear_cache;

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_valid [DEPTH];
    logic [31:0] m_tag   [DEPTH];
    logic [47:0] m_mac   [DEPTH];
    logic [31:0] pool    [8];

    always #5 clk = ~clk;

    ip_arp_cache #(
        .CACHE_ADDR_WIDTH(AW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .query_request_valid (query_request_valid),
        .query_request_ip    (query_request_ip),
        .query_request_ready (query_request_ready),
        .query_response_valid(query_response_valid),
        .query_response_error(query_response_error),
        .query_response_mac  (query_response_mac),
        .query_response_ready(query_response_ready),
        .write_request_valid (write_request_valid),
        .write_request_ip    (write_request_ip),
        .write_request_mac   (write_request_mac),
        .write_request_ready (write_request_ready),
        .clear_cache         (clear_cache)
    );

    function automatic int idx_of(input logic [31:0] ip);
        int hi;
        int lo;
        hi = int'(ip[31:16]);
        lo = int'(ip[15:0]);
        return (hi ^ lo) % DEPTH;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_write(input logic [31:0] ip, input logic [47:0] mac);
        int i;
        if (ip != 32'd0 && mac != 48'd0) begin
            i          = idx_of(ip);
            m_valid[i] = 1'b1;
            m_tag[i]   = ip;
            m_mac[i]   = mac;
        end
    endtask

    task automatic model_lookup(input logic [31:0] ip, output logic err, output logic [47:0] mac);
        int i;
`ifdef ARP_CACHE_BROADCAST_BYPASS_EN
        if (ip == 32'hFFFF_FFFF) begin
            err = 1'b0;
            mac = 48'hFFFF_FFFF_FFFF;
            return;
        end
`endif
        i = idx_of(ip);
        if (m_valid[i] && m_tag[i] == ip) begin
            err = 1'b0;
            mac = m_mac[i];
        end else begin
            err = 1'b1;
            mac = 48'd0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] ip, input logic [47:0] mac);
        write_request_valid = 1'b1;
        write_request_ip    = ip;
        write_request_mac   = mac;
        @(negedge clk);
        check("wr_ready", write_request_ready, 1);
        step();
        write_request_valid = 1'b0;
        model_write(ip, mac);
    endtask

    // Query with optional same-cycle write; expectation is taken before the write is modelled.
    task automatic do_query(input string tag, input logic [31:0] ip, input bit with_wr,
                            input logic [31:0] wip, input logic [47:0] wmac);
        logic        e;
        logic [47:0] m;
        model_lookup(ip, e, m);
        query_request_valid = 1'b1;
        query_request_ip    = ip;
        if (with_wr) begin
            write_request_valid = 1'b1;
            write_request_ip    = wip;
            write_request_mac   = wmac;
        end
        @(negedge clk);
        check({tag, "_qrdy"}, query_request_ready, 1);
        step();
        query_request_valid = 1'b0;
        write_request_valid = 1'b0;
        if (with_wr) model_write(wip, wmac);
        @(negedge clk);
        check({tag, "_lat1"}, query_response_valid, 0);
        step();
        @(negedge clk);
        check({tag, "_valid"}, query_response_valid, 1);
        check({tag, "_err"}, query_response_error, e);
        check({tag, "_mac"}, query_response_mac, m);
        step();
    endtask

    // Counts consecutive cycles with both readies low; optionally checks one in-flight hit.
    task automatic wait_sweep(input string tag, input bit chk_resp, input logic [47:0] exp_mac);
        int low;
        low = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (chk_resp && c == 1) begin
                check({tag, "_inflight_v"}, query_response_valid, 1);
                check({tag, "_inflight_err"}, query_response_error, 0);
                check({tag, "_inflight_mac"}, query_response_mac, exp_mac);
            end else if (c < 70) begin
                check({tag, "_noresp"}, query_response_valid, 0);
            end
            if (!query_request_ready && !write_request_ready) low++;
            else break;
            step();
        end
        check({tag, "_low_cycles"}, low, DEPTH);
        check({tag, "_qrdy_after"}, query_request_ready, 1);
        check({tag, "_wrdy_after"}, write_request_ready, 1);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ip_r;
        logic [47:0] mac_r;
        logic        e;
        logic [47:0] m;
        int          op;

        rst                  = 1'b1;
        query_request_valid  = 1'b0;
        query_request_ip     = 32'd0;
        query_response_ready = 1'b1;
        write_request_valid  = 1'b0;
        write_request_ip     = 32'd0;
        write_request_mac    = 48'd0;
        clear_cache          = 1'b0;
        model_clear();

        repeat (3) step();
        @(negedge clk);
        check("rst_resp_valid", query_response_valid, 0);
        check("rst_resp_err", query_response_error, 0);
        check("rst_resp_mac", query_response_mac, 0);
        check("rst_qrdy", query_request_ready, 0);
        check("rst_wrdy", write_request_ready, 0);
        step();
        rst = 1'b0;
        wait_sweep("rst_sweep", 1'b0, 48'd0);

        // Basic learn then hit.
        do_write(32'hC0A8_0102, 48'h0200_0000_0001);
        do_query("hit", 32'hC0A8_0102, 1'b0, 32'd0, 48'd0);

        // Miss with response stalled for 5 cycles.
        query_response_ready = 1'b0;
        query_request_valid  = 1'b1;
        query_request_ip     = 32'hC0A8_0199;
        @(negedge clk);
        check("stall_qrdy", query_request_ready, 1);
        step();
        query_request_valid = 1'b0;
        @(negedge clk);
        check("stall_lat1", query_response_valid, 0);
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", query_response_valid, 1);
            check("stall_err", query_response_error, 1);
            check("stall_mac", query_response_mac, 0);
            check("stall_qrdy_low", query_request_ready, 0);
            step();
        end
        query_response_ready = 1'b1;
        @(negedge clk);
        check("stall_release_qrdy", query_request_ready, 1);
        check("stall_release_valid", query_response_valid, 1);
        step();
        @(negedge clk);
        check("stall_drained", query_response_valid, 0);
        step();

        // C0A90003 folds to the same index as C0A80102 (AW=6), so it evicts it.
        do_write(32'hC0A9_0003, 48'h0200_0000_0002);
        do_query("evict_old", 32'hC0A8_0102, 1'b0, 32'd0, 48'd0);
        do_query("evict_new", 32'hC0A9_0003, 1'b0, 32'd0, 48'd0);
        do_write(32'hC0A9_0002, 48'h0200_0000_0003);
        do_query("second_ip", 32'hC0A9_0002, 1'b0, 32'd0, 48'd0);

        // Zero ip / zero mac writes are discarded.
        do_write(32'hC0A8_0105, 48'd0);
        do_write(32'd0, 48'h0200_0000_0055);
        do_query("discard_mac0", 32'hC0A8_0105, 1'b0, 32'd0, 48'd0);
        do_query("discard_ip0", 32'd0, 1'b0, 32'd0, 48'd0);

        // Same-cycle write and query: pre-write data, then the new entry.
        do_query("same_cyc", 32'hC0A8_0103, 1'b1, 32'hC0A8_0103, 48'h0200_0000_00AA);
        do_query("same_cyc_rep", 32'hC0A8_0103, 1'b0, 32'd0, 48'd0);
        do_write(32'hC0A8_0103, 48'h0200_0000_00BB);
        do_query("latest_wins", 32'hC0A8_0103, 1'b0, 32'd0, 48'd0);

        do_query("bcast", 32'hFFFF_FFFF, 1'b0, 32'd0, 48'd0);

        // Clear sweep with a query accepted in the pulse cycle.
        do_write(32'h0A00_0001, 48'h0A0A_0000_0001);
        do_write(32'h0A00_0002, 48'h0A0A_0000_0002);
        do_write(32'h0A00_0003, 48'h0A0A_0000_0003);
        model_lookup(32'h0A00_0001, e, m);
        query_request_valid = 1'b1;
        query_request_ip    = 32'h0A00_0001;
        clear_cache         = 1'b1;
        @(negedge clk);
        check("clr_qrdy_pulse", query_request_ready, 1);
        step();
        query_request_valid = 1'b0;
        clear_cache         = 1'b0;
        wait_sweep("clear", 1'b1, m);
        model_clear();
        do_query("clr_miss1", 32'h0A00_0001, 1'b0, 32'd0, 48'd0);
        do_query("clr_miss2", 32'h0A00_0002, 1'b0, 32'd0, 48'd0);
        do_query("clr_miss3", 32'h0A00_0003, 1'b0, 32'd0, 48'd0);

        // Random mix; pool[6] collides with pool[0], pool[7] with pool[1].
        for (int i = 0; i < 6; i++) pool[i] = $urandom;
        pool[6] = pool[0] ^ 32'h0001_0001;
        pool[7] = pool[1] ^ 32'h1234_1234;
        for (int it = 0; it < 80; it++) begin
            op = int'($urandom_range(0, 2));
            ip_r = pool[$urandom_range(0, 7)];
            if (op == 0) begin
                a = $urandom;
                b = $urandom;
                mac_r = {a[15:0], b};
                if ($urandom_range(0, 7) == 0) mac_r = 48'd0;
                if ($urandom_range(0, 7) == 0) ip_r = 32'd0;
                do_write(ip_r, mac_r);
            end else begin
                do_query("rnd_q", ip_r, 1'b0, 32'd0, 48'd0);
            end
        end

        // Reset mid-query: response dropped, table swept.
        do_write(32'h0B00_0001, 48'h0B0B_0000_0001);
        query_request_valid = 1'b1;
        query_request_ip    = 32'h0B00_0001;
        step();
        query_request_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", query_response_valid, 0);
        step();
        @(negedge clk);
        check("midrst_valid2", query_response_valid, 0);
        check("midrst_qrdy", query_request_ready, 0);
        check("midrst_wrdy", write_request_ready, 0);
        step();
        rst = 1'b0;
        wait_sweep("midrst_sweep", 1'b0, 48'd0);
        model_clear();
        do_query("midrst_miss", 32'h0B00_0001, 1'b0, 32'd0, 48'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
